// File: rtl/ucode_loader.sv
// ucode_loader: receives a byte-stream microcode frame over valid/ready and
// issues word writes into the control store. The CPU is held from reset until
// a frame whose checksum matches has been fully loaded.
module ucode_loader #(
  parameter int P_LOG_MEMSIZE    = 4,
  parameter int P_NUM_D_CTRLBITS = 5,
  parameter int P_NUM_C_CTRLBITS = 2,
  localparam int W = P_LOG_MEMSIZE + P_NUM_C_CTRLBITS + P_NUM_D_CTRLBITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [P_LOG_MEMSIZE-1:0] mem_waddr,
  output logic [W-1:0]             mem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

  // Remaining-word counter needs one extra bit so that N = 0 can mean 2^L.
  localparam int CW = P_LOG_MEMSIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_CSUM,
    S_FIN
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            remaining_q, remaining_d;
  logic [P_LOG_MEMSIZE-1:0] addr_q, addr_d;
  logic [7:0]               csum_q, csum_d;
  logic [7:0]               lo_q, lo_d;
  logic                     mem_we_q, mem_we_d;
  logic [P_LOG_MEMSIZE-1:0] mem_waddr_q, mem_waddr_d;
  logic [W-1:0]             mem_wdata_q, mem_wdata_d;
  logic                     cpu_hold_q, cpu_hold_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     accept;
  logic [P_LOG_MEMSIZE-1:0] hdr_n;

  // FIN is the only state that refuses bytes; it gives the result one cycle.
  assign in_ready = (state_q != S_FIN);
  assign accept   = in_valid & in_ready;
  assign hdr_n    = in_data[P_LOG_MEMSIZE-1:0];

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

  // Next-state and registered-output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    lo_d        = lo_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Header: a zero count addresses the whole store.
          if (hdr_n == '0) begin
            remaining_d = {1'b1, {P_LOG_MEMSIZE{1'b0}}};
          end else begin
            remaining_d = {1'b0, hdr_n};
          end
          addr_d     = '0;
          csum_d     = in_data;
          cpu_hold_d = 1'b1;
          err_d      = 1'b0;
          state_d    = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          // Write is issued regardless of the eventual checksum outcome.
          mem_we_d    = 1'b1;
          mem_waddr_d = addr_q;
          mem_wdata_d = W'({in_data, lo_q});
          csum_d      = csum_q ^ in_data;
          addr_d      = addr_q + P_LOG_MEMSIZE'(1);
          remaining_d = remaining_q - CW'(1);
          state_d     = (remaining_d != '0) ? S_LO : S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; active-low synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      csum_q      <= '0;
      lo_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      csum_q      <= csum_d;
      lo_q        <= lo_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/ucode_loader.md
# ucode_loader

Writer end of the control store: accepts a byte-stream microcode image over a valid/ready handshake and issues word writes into the `control` block's microcode memory. It holds the CPU (`cpu_hold`, which gates `en` of `top`) from reset until a frame with a correct checksum has been fully loaded. Each control-store word is {next address, condition-select bits, datapath control bits}, with width `W = P_LOG_MEMSIZE + P_NUM_C_CTRLBITS + P_NUM_D_CTRLBITS`.

## Interface
- `P_LOG_MEMSIZE`, default 4: address width; the control store holds 2^P_LOG_MEMSIZE words.
- `P_NUM_D_CTRLBITS`, default 5: number of datapath control bits per word.
- `P_NUM_C_CTRLBITS`, default 2: number of condition-select bits per word.
- Constraint: W ≤ 16. With the defaults, W = 11.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte. A byte transfers when `in_valid & in_ready` at a clock edge.
- `mem_we`  out  1  control-store write strobe.
- `mem_waddr`  out  P_LOG_MEMSIZE  write address.
- `mem_wdata`  out  W  write data.
- `cpu_hold`  out  1  1 = CPU must not advance.
- `done`  out  1  one-cycle pulse: frame loaded, checksum good.
- `err`  out  1  checksum mismatch on the last frame; level signal.

## Operation
- Frame format: header byte N, then N words of 2 bytes each (LO byte first, then HI byte), then a checksum byte.
  - Word count: N = 0 means 2^P_LOG_MEMSIZE words. For N > 2^P_LOG_MEMSIZE, only the low P_LOG_MEMSIZE bits of N are used.
  - Word value: {HI, LO}[W-1:0]; HI bits above W-9 are ignored.
  - Checksum: XOR of the header byte and all word bytes. The frame is good when the checksum byte equals this XOR.
- FSM states:
  - IDLE: `in_ready`=1. On byte accept:
    - latch N, remaining = N (0 → 2^L);
    - addr = 0, csum = byte;
    - `cpu_hold` ← 1, `err` ← 0;
    - go to LO.
  - LO: `in_ready`=1. On accept: latch the byte, csum ^= byte, go to HI.
  - HI: `in_ready`=1. On accept:
    - register the write (waddr = addr, wdata = {byte, lo}[W-1:0]) and pulse `mem_we` next cycle;
    - csum ^= byte, addr += 1, remaining -= 1;
    - go to LO if remaining is still > 0 after the decrement, else go to CSUM.
  - CSUM: `in_ready`=1. On accept: compare the byte to csum, go to FIN.
  - FIN: one cycle, `in_ready`=0, then go to IDLE.
    - Match: `done`=1, `cpu_hold` ← 0.
    - Mismatch: `err` ← 1, `cpu_hold` stays 1.
- Writes are never suppressed: even a frame with a bad checksum has already been written. Only the hold release depends on the checksum.
- The address counter is P_LOG_MEMSIZE bits wide. For N = 0 it goes 0..2^L-1; the final increment wraps it to 0 unused.
- With `in_valid` low, state holds indefinitely; there is no timeout.

## Timing
- Reset values, applied at an edge with `rst`=0 (the edge that samples reset):
  - state = IDLE;
  - `in_ready`=1, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0;
  - `cpu_hold`=1, `done`=0, `err`=0;
  - internal counters = 0.
- Reset has priority over any handshake in the same cycle.
- Reset mid-frame: the partial frame is discarded and the next byte is treated as a header. Words already written remain in the control store.
- Write latency: `mem_we` is high exactly one cycle, the cycle after the HI byte handshake. Address and data are valid in that same cycle.
- The loader accepts one byte per cycle back-to-back in IDLE/LO/HI/CSUM.
- In FIN, a presented byte is not taken. It is accepted in the following cycle as a new header.
- `done` and the fall of `cpu_hold` occur in the same cycle, the cycle after the checksum handshake.
- `err` rises in the same cycle and stays high until the next header is accepted or reset.

## Test plan
- **Good 2-word frame.** Bytes 02,23,01,FF,07,D8 back-to-back → writes (0,0x123) and (1,0x7FF), each one cycle after its HI byte; `done` pulses once; `cpu_hold` drops to 0; `err` stays 0.
- **Bad checksum.** Same frame with checksum D9 → the same two writes occur; `err`=1; `done` stays 0; `cpu_hold` stays 1. A following good frame clears `err` at its header, then releases hold.
- **Full store, N=00.** 16 words with data = address (LO=i, HI=00), plus the correct checksum → writes to addresses 0..15 with data 0..15 in order; no 17th write; `done` pulses.
- **Bit masking.** N=01, LO=00, HI=F8 → `mem_wdata`=0x000. LO=AA, HI=FD → `mem_wdata`=0x5AA.
- **Backpressure and gaps.** Random `in_valid` gaps give the same writes as back-to-back. A byte held valid during FIN is not consumed until the next cycle and is then taken as a header.
- **Reset mid-frame.** Pulse `rst`=0 after the first LO byte → all outputs return to reset values, including `cpu_hold`=1; no write issued; a subsequent good frame loads from address 0.
